bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bin_to_bcd_seq.sv | 122 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter using shift-and-add-3.
// Latches one unsigned binary value per start and needs BIN_W shift cycles.
// The result registers hold their value until the next conversion completes.
// Optional macro BIN_TO_BCD_BLANK_EN: leading zero digits above digit 0
// are loaded as 4'hF, the blank code for the display driver.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(BIN_W + 1);

  // One-hot style encoding: busy and done are each a bare state flop.
  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_SHIFT = 2'b01;
  localparam logic [1:0] S_DONE  = 2'b10;

  logic [1:0]          r_state;
  logic [BIN_W-1:0]    r_bin;
  logic [SW-1:0]       r_scratch;
  logic [CW-1:0]       r_cnt;
  logic                r_sticky;
  logic [SW-1:0]       r_bcd;
  logic                r_ovf;

  logic [SW-1:0]       w_adj;
  logic [SW+BIN_W-1:0] w_shifted;
  logic [SW-1:0]       w_scratch_nxt;
  logic [BIN_W-1:0]    w_bin_nxt;
  logic                w_out_bit;
  logic                w_last;
  logic [SW-1:0]       w_load;

  // Add 3 to every scratch digit that is 5 or more (no carry between digits).
  always_comb begin
    w_adj = r_scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
    end
  end

  // Scratch and binary shift as one word so BIN_W=1 needs no special case.
  assign w_shifted     = {w_adj, r_bin} << 1;
  assign w_out_bit     = w_adj[SW-1];
  assign w_scratch_nxt = w_shifted[SW+BIN_W-1 -: SW];
  assign w_bin_nxt     = w_shifted[BIN_W-1:0];
  assign w_last        = (r_cnt == CW'(1));

`ifdef BIN_TO_BCD_BLANK_EN
  logic w_lead;

  // Replace leading zero digits (never digit 0) with the blank code.
  always_comb begin
    w_load = w_scratch_nxt;
    w_lead = 1'b1;
    for (int unsigned k = 0; k < DIGITS - 1; k++) begin
      if (w_lead && (w_scratch_nxt[4*(DIGITS-1-k) +: 4] == 4'd0))
        w_load[4*(DIGITS-1-k) +: 4] = 4'hF;
      else
        w_lead = 1'b0;
    end
  end
`else
  assign w_load = w_scratch_nxt;
`endif

  // Conversion FSM; results load on the same edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_bin     <= bin;
            r_scratch <= '0;
            r_sticky  <= 1'b0;
            r_cnt     <= CW'(BIN_W);
            r_state   <= S_SHIFT;
          end else begin
            r_state   <= S_IDLE;
          end
        end
        S_SHIFT: begin
          r_bin     <= w_bin_nxt;
          r_scratch <= w_scratch_nxt;
          r_cnt     <= r_cnt - 1'b1;
          r_sticky  <= r_sticky | w_out_bit;
          if (w_last) begin
            r_state <= S_DONE;
            r_bcd   <= w_load;
            r_ovf   <= r_sticky | w_out_bit;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_state[0];
  assign done     = r_state[1];
  assign bcd      = r_bcd;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: default 8-bit/3-digit instance plus a 10-bit
// instance for overflow cases. Expected results are queued at start and
// popped by a monitor when done pulses.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        busy8, done8, ovf8;
  logic [11:0] bcd8;
  logic        start10 = 1'b0;
  logic [9:0]  bin10 = '0;
  logic        busy10, done10, ovf10;
  logic [11:0] bcd10;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [12:0] q8[$];
  logic [12:0] q10[$];

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin(bin8),
    .busy(busy8), .done(done8), .bcd(bcd8), .overflow(ovf8)
  );

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .bin(bin10),
    .busy(busy10), .done(done10), .bcd(bcd10), .overflow(ovf10)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] blank(input logic [11:0] raw);
    logic [11:0] r = raw;
`ifdef BIN_TO_BCD_BLANK_EN
    if (r[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (r[7:4] == 4'd0) r[7:4] = 4'hF;
    end
`endif
    return r;
  endfunction

  // Reference by repeated division; overflow when quotient remains.
  function automatic logic [12:0] model(input int unsigned v);
    logic [11:0] raw;
    int unsigned t = v;
    for (int d = 0; d < 3; d++) begin
      raw[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {(t != 0), blank(raw)};
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [12:0] e;
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL done8_unexpected: got done with empty queue, required none (t=%0t)", $time);
      end else begin
        e = q8.pop_front();
        chk("bcd8", {20'd0, bcd8}, {20'd0, e[11:0]});
        chk("ovf8", {31'd0, ovf8}, {31'd0, e[12]});
      end
    end
    if (rst_n && done10) begin
      if (q10.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL done10_unexpected: got done with empty queue, required none (t=%0t)", $time);
      end else begin
        e = q10.pop_front();
        chk("bcd10", {20'd0, bcd10}, {20'd0, e[11:0]});
        chk("ovf10", {31'd0, ovf10}, {31'd0, e[12]});
      end
    end
  end

  task automatic wait_idle8();
    int t = 0;
    while ((busy8 || done8) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("idle8_timeout", {31'd0, busy8 | done8}, 32'd0);
  endtask

  task automatic run8(input logic [7:0] b, input logic [12:0] exp, input bit inject);
    wait_idle8();
    start8 = 1'b1;
    bin8   = b;
    q8.push_back(exp);
    @(posedge clk);
    #1 start8 = 1'b0;
    bin8 = ~b;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("busy8", {31'd0, busy8}, 32'd1);
      chk("done8_early", {31'd0, done8}, 32'd0);
      if (inject && i == 2) start8 = 1'b1;
      if (inject && i == 4) start8 = 1'b0;
    end
    @(negedge clk);
    chk("done8_on_time", {31'd0, done8}, 32'd1);
    chk("busy8_in_done", {31'd0, busy8}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("bcd8_hold", {20'd0, bcd8}, {20'd0, exp[11:0]});
  endtask

  task automatic run10(input logic [9:0] b);
    int found = -1;
    start10 = 1'b1;
    bin10   = b;
    q10.push_back(model(b));
    @(posedge clk);
    #1 start10 = 1'b0;
    bin10 = ~b;
    for (int i = 0; i < 20 && found < 0; i++) begin
      @(negedge clk);
      if (done10) found = i;
    end
    chk("done10_latency", found, 32'd10);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] raw;
  } vec_t;

  initial begin
    vec_t tbl[10];
    int   perm[256];
    int   c1, c2;

    tbl[0] = '{8'd0,   12'h000};
    tbl[1] = '{8'd7,   12'h007};
    tbl[2] = '{8'd40,  12'h040};
    tbl[3] = '{8'd9,   12'h009};
    tbl[4] = '{8'd10,  12'h010};
    tbl[5] = '{8'd99,  12'h099};
    tbl[6] = '{8'd100, 12'h100};
    tbl[7] = '{8'd128, 12'h128};
    tbl[8] = '{8'd200, 12'h200};
    tbl[9] = '{8'd255, 12'h255};

    // Reset state
    @(negedge clk);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_bcd8", {20'd0, bcd8}, 32'd0);
    chk("rst_ovf8", {31'd0, ovf8}, 32'd0);
    chk("rst_bcd10", {20'd0, bcd10}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_self_start", {31'd0, busy8 | busy10}, 32'd0);

    // Table-driven vectors; every other one pokes start during SHIFT
    for (int i = 0; i < 10; i++)
      run8(tbl[i].bin, {1'b0, blank(tbl[i].raw)}, bit'(i % 2));

    // Overflow boundary on the 10-bit instance
    run10(10'd999);
    run10(10'd1000);
    run10(10'd1023);
    run10(10'd0);
    run10(10'd512);

    // Back-to-back with start held high: 123 then 45
    wait_idle8();
    start8 = 1'b1;
    bin8   = 8'd123;
    q8.push_back({1'b0, blank(12'h123)});
    @(posedge clk);
    #1 bin8 = 8'd45;
    q8.push_back({1'b0, blank(12'h045)});
    c1 = -1;
    c2 = -1;
    for (int i = 0; i < 40 && c2 < 0; i++) begin
      @(negedge clk);
      if (done8) begin
        if (c1 < 0) c1 = cyc;
        else c2 = cyc;
      end else if (c1 >= 0) begin
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    chk("b2b_spacing", c2 - c1, 32'd9);

    // Reset three cycles into converting 200: aborted, outputs cleared
    wait_idle8();
    start8 = 1'b1;
    bin8   = 8'd200;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy8", {31'd0, busy8}, 32'd0);
    chk("abort_done8", {31'd0, done8}, 32'd0);
    chk("abort_bcd8", {20'd0, bcd8}, 32'd0);
    chk("abort_ovf8", {31'd0, ovf8}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", {31'd0, busy8 | done8}, 32'd0);
    chk("abort_bcd8_held", {20'd0, bcd8}, 32'd0);
    run8(8'd99, {1'b0, blank(12'h099)}, 1'b0);

    // Full sweep in shuffled order against the division model
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      int t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++)
      run8(8'(perm[i]), model(perm[i]), 1'b0);

    repeat (5) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q10_drained", q10.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
